// File: rtl/weight_fetch_sequencer.sv
// Weight fetch sequencer: controls an optional weight preload into the BRAM,
// then streams the weight words (two per BRAM address, port A then port B)
// to the MAC array with a valid/ready handshake.
module weight_fetch_sequencer #(
    parameter int BRAM_ADDRESS_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic        cfg_load_weights,
    input  logic [4:0]  cfg_kernel_size,
    input  logic [11:0] cfg_output_channel_size,
    input  logic        cfg_abort,
    output logic        write_en,
    output logic        transfer_start,
    output logic        bram_control_add1,
    output logic        bram_control_add2,
    output logic        port_sel,
    input  logic        weight_from_bram_valid,
    input  logic        write_weight_finish,
    output logic        mac_weight_valid,
    input  logic        mac_weight_ready,
    output logic        busy,
    output logic        done,
    output logic        cfg_error
);

    // The controller's address counter must hold at least one word pair.
    if (BRAM_ADDRESS_WIDTH < 1) begin : g_bad_addr_width
        $error("BRAM_ADDRESS_WIDTH must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WSTART,
        WLOAD,
        RSTART,
        RWAIT,
        RHOLD,
        STEP,
        DONE
    } state_t;

    state_t      state;
    logic [14:0] remaining;
    logic        port_sel_q;
    logic        cfg_error_q;

    logic [14:0] ch_w;
    logic [14:0] word_total;
    logic        cfg_ok;
    logic        pair_step;
    logic [14:0] step_sz;

    assign ch_w      = {3'b000, cfg_output_channel_size};
    // A zero total covers both a zero channel count and a non-one-hot kernel.
    assign cfg_ok    = (word_total != 15'd0);
    assign pair_step = |remaining[14:1];
    assign step_sz   = pair_step ? 15'd2 : 15'd1;

    // Word total = kernel size (1..5 from the one-hot code) times channel count.
    always_comb begin
        word_total = 15'd0;
        case (cfg_kernel_size)
            5'b00001: word_total = ch_w;
            5'b00010: word_total = ch_w << 1;
            5'b00100: word_total = (ch_w << 1) + ch_w;
            5'b01000: word_total = ch_w << 2;
            5'b10000: word_total = (ch_w << 2) + ch_w;
            default:  word_total = 15'd0;
        endcase
    end

    // Sequencer state, remaining word count, port select and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= 15'd0;
            port_sel_q  <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= 1'b0;
            if (cfg_abort) begin
                state      <= IDLE;
                remaining  <= 15'd0;
                port_sel_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_start) begin
                            if (cfg_ok) begin
                                remaining  <= word_total;
                                port_sel_q <= 1'b0;
                                state      <= cfg_load_weights ? WSTART : RSTART;
                            end else begin
                                cfg_error_q <= 1'b1;
                            end
                        end
                    end
                    WSTART: state <= WLOAD;
                    WLOAD: begin
                        if (write_weight_finish) state <= RSTART;
                    end
                    RSTART: begin
                        port_sel_q <= 1'b0;
                        state      <= RWAIT;
                    end
                    RWAIT: begin
                        if (weight_from_bram_valid) state <= RHOLD;
                    end
                    RHOLD: begin
                        // Port A word of a full pair is followed by the port B word
                        // from the same BRAM read; otherwise advance the address.
                        if (mac_weight_ready) begin
                            if (pair_step && !port_sel_q) port_sel_q <= 1'b1;
                            else                          state      <= STEP;
                        end
                    end
                    STEP: begin
                        port_sel_q <= 1'b0;
                        remaining  <= remaining - step_sz;
                        state      <= (remaining == step_sz) ? DONE : RWAIT;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign write_en          = (state == WSTART) || (state == WLOAD);
    assign transfer_start    = (state == WSTART) || (state == RSTART);
    assign bram_control_add2 = (state == STEP) && pair_step;
    assign bram_control_add1 = (state == STEP) && !pair_step;
    assign port_sel          = port_sel_q;
    assign mac_weight_valid  = (state == RHOLD);
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);
    assign cfg_error         = cfg_error_q;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: table of jobs plus hand-written abort,
// stall and reset sequences, with a BRAM latency model and a scoreboard of
// expected port_sel per accepted word and expected address step sizes.
module tb_weight_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic        cfg_load_weights;
    logic [4:0]  cfg_kernel_size;
    logic [11:0] cfg_output_channel_size;
    logic        cfg_abort;
    logic        write_en;
    logic        transfer_start;
    logic        bram_control_add1;
    logic        bram_control_add2;
    logic        port_sel;
    logic        weight_from_bram_valid;
    logic        write_weight_finish;
    logic        mac_weight_valid;
    logic        mac_weight_ready;
    logic        busy;
    logic        done;
    logic        cfg_error;

    weight_fetch_sequencer #(.BRAM_ADDRESS_WIDTH(12)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cfg_start               (cfg_start),
        .cfg_load_weights        (cfg_load_weights),
        .cfg_kernel_size         (cfg_kernel_size),
        .cfg_output_channel_size (cfg_output_channel_size),
        .cfg_abort               (cfg_abort),
        .write_en                (write_en),
        .transfer_start          (transfer_start),
        .bram_control_add1       (bram_control_add1),
        .bram_control_add2       (bram_control_add2),
        .port_sel                (port_sel),
        .weight_from_bram_valid  (weight_from_bram_valid),
        .write_weight_finish     (write_weight_finish),
        .mac_weight_valid        (mac_weight_valid),
        .mac_weight_ready        (mac_weight_ready),
        .busy                    (busy),
        .done                    (done),
        .cfg_error               (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_ps_q[$];
    int exp_step_q[$];
    int add1_cnt = 0;
    int add2_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int ts_cyc = 0;
    bit lat_pending = 0;
    logic [3:0] pipe = 4'b0;

    typedef struct {
        bit       load;
        bit [4:0] kernel;
        int       ch;
        int       fin_dly;
        bit       exp_err;
        int       exp_add2;
        int       exp_add1;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({write_en, transfer_start, bram_control_add1, bram_control_add2, port_sel,
                     mac_weight_valid, busy, done, cfg_error});
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_sb();
        exp_ps_q.delete();
        exp_step_q.delete();
        add1_cnt = 0;
        add2_cnt = 0;
        done_cnt = 0;
    endtask

    // Reference pair rule: full pairs read port A then port B and step by 2,
    // a trailing single word reads port A and steps by 1.
    task automatic push_expect(input int n);
        int r;
        r = n;
        while (r > 0) begin
            if (r >= 2) begin
                exp_ps_q.push_back(0);
                exp_ps_q.push_back(1);
                exp_step_q.push_back(2);
                r -= 2;
            end else begin
                exp_ps_q.push_back(0);
                exp_step_q.push_back(1);
                r -= 1;
            end
        end
    endtask

    // BRAM latency model and output monitor, sampling on the falling edge.
    initial begin
        weight_from_bram_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pipe = 4'b0;
                weight_from_bram_valid = 1'b0;
                lat_pending = 0;
            end else begin
                if (mac_weight_valid && mac_weight_ready) begin
                    chk("word_expected", int'(exp_ps_q.size() > 0), 1);
                    if (exp_ps_q.size() > 0) chk("port_sel", int'(port_sel), exp_ps_q.pop_front());
                end
                if (bram_control_add1 || bram_control_add2) begin
                    if (bram_control_add1) add1_cnt++;
                    if (bram_control_add2) add2_cnt++;
                    chk("step_expected", int'(exp_step_q.size() > 0), 1);
                    if (exp_step_q.size() > 0)
                        chk("step_size", int'({bram_control_add2, bram_control_add1}), exp_step_q.pop_front());
                end
                if (done) done_cnt++;
                if (transfer_start && !write_en) begin
                    ts_cyc = cyc;
                    lat_pending = 1;
                end
                if (mac_weight_valid && lat_pending) begin
                    chk("read_latency", cyc - ts_cyc, 4);
                    lat_pending = 0;
                end
                pipe = {pipe[2:0], (transfer_start && !write_en) || bram_control_add1 || bram_control_add2};
                weight_from_bram_valid = pipe[3];
            end
        end
    end

    task automatic wait_valid();
        int g;
        g = 0;
        while (!mac_weight_valid && g < 100) begin
            tick();
            g++;
        end
        chk("valid_seen", int'(mac_weight_valid), 1);
    endtask

    task automatic wait_done(input int exp_add2, input int exp_add1);
        int g;
        g = 0;
        while (done_cnt == 0 && g < 3000) begin
            tick();
            g++;
        end
        tick();
        tick();
        chk("done_count", done_cnt, 1);
        chk("busy_after_done", int'(busy), 0);
        chk("add2_count", add2_cnt, exp_add2);
        chk("add1_count", add1_cnt, exp_add1);
        chk("words_left", exp_ps_q.size(), 0);
    endtask

    task automatic start_job(input bit load, input bit [4:0] kernel, input int ch);
        cfg_load_weights        = load;
        cfg_kernel_size         = kernel;
        cfg_output_channel_size = 12'(ch);
        cfg_start               = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        int k;
        k = 0;
        for (int i = 0; i < 5; i++)
            if (v.kernel == 5'(1 << i)) k = i + 1;
        clear_sb();
        if (!v.exp_err) push_expect(k * v.ch);
        start_job(v.load, v.kernel, v.ch);
        chk("cfg_error", int'(cfg_error), int'(v.exp_err));
        chk("busy_after_start", int'(busy), int'(!v.exp_err));
        if (v.exp_err) begin
            tick();
            chk("cfg_error_one_pulse", int'(cfg_error), 0);
            chk("busy_after_error", int'(busy), 0);
            chk("outputs_after_error", outs(), 0);
        end else begin
            if (v.load) begin
                chk("wstart", int'({transfer_start, write_en}), 3);
                for (int i = 0; i < v.fin_dly; i++) begin
                    tick();
                    chk("wload_hold", int'({write_en, transfer_start, mac_weight_valid}), 4);
                end
                write_weight_finish = 1'b1;
                tick();
                write_weight_finish = 1'b0;
            end
            chk("rstart", int'({transfer_start, write_en, port_sel}), 4);
            wait_done(v.exp_add2, v.exp_add1);
        end
    endtask

    initial begin
        rst                     = 1'b1;
        cfg_start               = 1'b0;
        cfg_load_weights        = 1'b0;
        cfg_kernel_size         = 5'b0;
        cfg_output_channel_size = 12'd0;
        cfg_abort               = 1'b0;
        write_weight_finish     = 1'b0;
        mac_weight_ready        = 1'b1;

        tbl[0] = '{load: 0, kernel: 5'b00100, ch: 2, fin_dly: 0,  exp_err: 0, exp_add2: 3, exp_add1: 0};
        tbl[1] = '{load: 1, kernel: 5'b00001, ch: 3, fin_dly: 10, exp_err: 0, exp_add2: 1, exp_add1: 1};
        tbl[2] = '{load: 0, kernel: 5'b00001, ch: 0, fin_dly: 0,  exp_err: 1, exp_add2: 0, exp_add1: 0};
        tbl[3] = '{load: 0, kernel: 5'b00110, ch: 4, fin_dly: 0,  exp_err: 1, exp_add2: 0, exp_add1: 0};
        tbl[4] = '{load: 0, kernel: 5'b10000, ch: 3, fin_dly: 0,  exp_err: 0, exp_add2: 7, exp_add1: 1};
        tbl[5] = '{load: 1, kernel: 5'b01000, ch: 1, fin_dly: 2,  exp_err: 0, exp_add2: 2, exp_add1: 0};
        tbl[6] = '{load: 0, kernel: 5'b00010, ch: 5, fin_dly: 0,  exp_err: 0, exp_add2: 5, exp_add1: 0};
        tbl[7] = '{load: 0, kernel: 5'b00000, ch: 5, fin_dly: 0,  exp_err: 1, exp_add2: 0, exp_add1: 0};

        #1;
        chk("reset_outputs", outs(), 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("idle_outputs", outs(), 0);

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        // Stall: ready low for 5 cycles while a word is presented.
        clear_sb();
        mac_weight_ready = 1'b0;
        push_expect(2);
        start_job(1'b0, 5'b00001, 2);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", int'({mac_weight_valid, port_sel, bram_control_add1, bram_control_add2}), 8);
            tick();
        end
        mac_weight_ready = 1'b1;
        wait_done(1, 0);

        // Abort during the preload phase; a start in the same cycle is ignored.
        clear_sb();
        start_job(1'b1, 5'b00001, 1);
        tick();
        chk("wload_before_abort", int'({write_en, busy}), 3);
        cfg_abort = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        chk("abort_wload", int'({busy, write_en, cfg_error}), 0);
        repeat (5) tick();
        chk("abort_wload_idle", int'({busy, done_cnt != 0}), 0);

        // Abort while a word is being held for the MAC array.
        clear_sb();
        mac_weight_ready = 1'b0;
        push_expect(2);
        start_job(1'b0, 5'b00010, 1);
        wait_valid();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("abort_rhold", int'({busy, mac_weight_valid}), 0);
        repeat (8) tick();
        chk("abort_rhold_no_done", done_cnt, 0);
        chk("abort_rhold_no_step", add1_cnt + add2_cnt, 0);
        mac_weight_ready = 1'b1;

        // Reset mid-read drops every output at once.
        clear_sb();
        mac_weight_ready = 1'b0;
        push_expect(4);
        start_job(1'b0, 5'b00001, 4);
        wait_valid();
        rst = 1'b1;
        #1;
        chk("reset_mid_read", outs(), 0);
        tick();
        rst = 1'b0;
        clear_sb();
        mac_weight_ready = 1'b1;
        repeat (8) tick();
        chk("after_reset_idle", int'({busy, done_cnt != 0}), 0);

        // A fresh job after reset runs normally.
        run_job(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_fetch_sequencer.md
WEIGHT_FETCH_SEQUENCER -- requirements
Module: weight_fetch_sequencer

Interface
REQ-001 Parameter: BRAM_ADDRESS_WIDTH, default 12, width of the weight BRAM address counter in the sequenced BRAM controller.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; one clock, asynchronous and active-high.
REQ-004 cfg_start  in  1  one-cycle request to start a job; ignored unless idle.
REQ-005 cfg_load_weights  in  1  sampled with cfg_start; 1 = run write (preload) phase before read phase.
REQ-006 cfg_kernel_size  in  5  one-hot kernel size (bit n = size n+1), sampled with cfg_start.
REQ-007 cfg_output_channel_size  in  12  output channel count, sampled with cfg_start.
REQ-008 cfg_abort  in  1  synchronous abort; highest priority after rst.
REQ-009 write_en  out  1  write phase select to BRAM controller.
REQ-010 transfer_start  out  1  one-cycle start pulse to BRAM controller.
REQ-011 bram_control_add1 / bram_control_add2  out  1 each  one-cycle address step by 1 / by 2.
REQ-012 port_sel  out  1  0 = port A word, 1 = port B word presented on weight_out.
REQ-013 weight_from_bram_valid  in  1  BRAM read data valid.
REQ-014 write_weight_finish  in  1  BRAM controller has written all weight words.
REQ-015 mac_weight_valid  out  1  weight word available to MAC array.
REQ-016 mac_weight_ready  in  1  MAC array accepts word when high with mac_weight_valid.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse on job completion.
REQ-019 cfg_error  out  1  one-cycle pulse on rejected cfg_start.

Function
REQ-020 States: IDLE, WSTART, WLOAD, RSTART, RWAIT, RHOLD, STEP, DONE; all outputs Moore-decoded from registered state, port_sel and counters.
REQ-021 Word total N = k * cfg_output_channel_size, k = 1..5 from one-hot bit; latched into 15-bit remaining counter at accepted start (max 20475, no overflow).
REQ-022 cfg_start in IDLE with cfg_output_channel_size==0 or cfg_kernel_size not one-hot: cfg_error pulses next cycle, state stays IDLE, no output toggles.
REQ-023 Valid start: cfg_load_weights=1 -> WSTART; else -> RSTART.
REQ-024 WSTART (1 cycle): transfer_start=1, write_en=1; -> WLOAD.
REQ-025 WLOAD: write_en=1; on write_weight_finish=1 -> RSTART next cycle.
REQ-026 RSTART (1 cycle): transfer_start=1, write_en=0, port_sel=0; -> RWAIT.
REQ-027 RWAIT: wait weight_from_bram_valid=1 -> RHOLD; valid in the RSTART or STEP cycle itself never counted.
REQ-028 RHOLD: mac_weight_valid=1; stays until mac_weight_ready=1; valid never drops without acceptance.
REQ-029 Pair rule: remaining>=2 -> on acceptance with port_sel=0 set port_sel=1, stay RHOLD; acceptance with port_sel=1 -> STEP (step 2). remaining==1 -> acceptance with port_sel=0 -> STEP (step 1).
REQ-030 STEP (1 cycle): exactly one of bram_control_add2/add1 asserted per REQ-029; remaining decremented by 2/1; port_sel cleared; -> DONE if new remaining==0, else RWAIT.
REQ-031 DONE (1 cycle): done=1; -> IDLE.
REQ-032 Minimum read latency: RSTART to first mac_weight_valid = 4 cycles (RSTART, 2 BRAM pipeline cycles, RVALID seen).
REQ-033 cfg_abort in any non-IDLE state: -> IDLE next cycle, write_en/mac_weight_valid drop, no done, no add pulse; cfg_start in same cycle ignored.
REQ-034 cfg_start while busy ignored, no cfg_error.

Reset
REQ-035 rst=1 asynchronously forces IDLE; remaining=0; port_sel, write_en, transfer_start, add1, add2, mac_weight_valid, busy, done, cfg_error all 0.
REQ-036 Reset mid-job discards job; after release, block responds only to a new cfg_start.

Verification
REQ-037 k=3 (00100), channels=2, load=0, ready=1 -> 6 words, add2 x3, no add1, done once, port_sel 0,1 per pair.
REQ-038 k=1, channels=3, load=1 -> WSTART pulse with write_en; hold finish low 10 cycles (write_en held); finish -> RSTART; 3 words: add2 once, add1 once.
REQ-039 channels=0 or kernel 00110 -> cfg_error one pulse, busy stays 0.
REQ-040 mac_weight_ready low 5 cycles in RHOLD -> mac_weight_valid and port_sel stable, no add pulse.
REQ-041 cfg_abort during WLOAD and during RHOLD -> IDLE next cycle, no done; rst asserted mid-read -> all outputs 0 immediately.
